// File: rtl/drop_controller_if.sv
// drop_controller_if: request/status bundle between the drop sequencer and its neighbours.
//   drop_req        start a drop operation (sampled only while idle)
//   abort           cancel an operation in settle/eval/count
//   height[7:0]     fused sensor height, 0 = no valid sensor pair
//   busy            high whenever the sequencer is not idle
//   drop_activated  actuator strobe
//   done            one-cycle completion / error-exit / abort pulse
//   error           high while holding in the error state
//   status[2:0]     state code: 0 idle, 1 settle, 2 eval, 3 count, 4 drop, 5 error
// master: the requesting side; slave: the sequencer.
interface drop_controller_if;
    logic       drop_req;
    logic       abort;
    logic [7:0] height;
    logic       busy;
    logic       drop_activated;
    logic       done;
    logic       error;
    logic [2:0] status;

    modport master (
        output drop_req, abort, height,
        input  busy, drop_activated, done, error, status
    );

    modport slave (
        input  drop_req, abort, height,
        output busy, drop_activated, done, error, status
    );
endinterface

// File: rtl/drop_controller.sv
// drop_controller: sequences one baggage-drop operation around the fused height input.
// A request captures the height, waits for it to hold steady, validates it, counts down
// height * PRESCALE cycles and then strobes the drop actuator for DROP_PULSE cycles.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  drop_controller_if.slave (drop_req, abort, height in; busy, drop_activated, done,
//        error, status out). Every output is a register.
module drop_controller #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned H_MAX         = 200,
    parameter int unsigned PRESCALE      = 2,
    parameter int unsigned DROP_PULSE    = 3,
    parameter int unsigned ERR_HOLD      = 8
) (
    input  logic            clk,
    input  logic            rst,
    drop_controller_if.slave bus
);

    localparam int unsigned StableW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned RetryW  = $clog2(MAX_RETRY + 2);
    localparam int unsigned PreW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned HoldMax = (DROP_PULSE > ERR_HOLD) ? DROP_PULSE : ERR_HOLD;
    localparam int unsigned HoldW   = $clog2(HoldMax + 1);

    // With a one-cycle hold the done pulse coincides with the entry cycle.
    localparam bit DropDoneOnEntry = (DROP_PULSE == 1);
    localparam bit ErrDoneOnEntry  = (ERR_HOLD == 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSettle = 3'd1,
        StEval   = 3'd2,
        StCount  = 3'd3,
        StDrop   = 3'd4,
        StError  = 3'd5
    } state_e;

    state_e            state_q;
    logic [7:0]        h_ref_q;
    logic [StableW-1:0] stable_cnt_q;
    logic [RetryW-1:0] retry_cnt_q;
    logic [PreW-1:0]   prescale_cnt_q;
    logic [7:0]        unit_cnt_q;
    // Shared by DROP and ERROR: the two holds never overlap.
    logic [HoldW-1:0]  pulse_cnt_q;
    logic              busy_q;
    logic              drop_q;
    logic              done_q;
    logic              error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            h_ref_q        <= '0;
            stable_cnt_q   <= '0;
            retry_cnt_q    <= '0;
            prescale_cnt_q <= '0;
            unit_cnt_q     <= '0;
            pulse_cnt_q    <= '0;
            busy_q         <= 1'b0;
            drop_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.drop_req) begin
                        h_ref_q        <= bus.height;
                        stable_cnt_q   <= '0;
                        retry_cnt_q    <= '0;
                        prescale_cnt_q <= '0;
                        unit_cnt_q     <= '0;
                        pulse_cnt_q    <= '0;
                        busy_q         <= 1'b1;
                        state_q        <= StSettle;
                    end
                end

                StSettle: begin
                    if (bus.abort) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (bus.height == h_ref_q) begin
                        stable_cnt_q <= stable_cnt_q + StableW'(1);
                        if (stable_cnt_q == StableW'(STABLE_CYCLES - 1)) begin
                            state_q <= StEval;
                        end
                    end else if (retry_cnt_q == RetryW'(MAX_RETRY)) begin
                        // This change would be one more than tolerated.
                        state_q     <= StError;
                        error_q     <= 1'b1;
                        pulse_cnt_q <= '0;
                        done_q      <= ErrDoneOnEntry;
                    end else begin
                        h_ref_q      <= bus.height;
                        stable_cnt_q <= '0;
                        retry_cnt_q  <= retry_cnt_q + RetryW'(1);
                    end
                end

                StEval: begin
                    if (bus.abort) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (h_ref_q == 8'd0 || 32'(h_ref_q) > H_MAX) begin
                        state_q     <= StError;
                        error_q     <= 1'b1;
                        pulse_cnt_q <= '0;
                        done_q      <= ErrDoneOnEntry;
                    end else begin
                        unit_cnt_q     <= h_ref_q;
                        prescale_cnt_q <= PreW'(PRESCALE - 1);
                        state_q        <= StCount;
                    end
                end

                StCount: begin
                    // Nested counters give h_ref * PRESCALE cycles without a multiplier.
                    if (bus.abort) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (prescale_cnt_q == '0) begin
                        prescale_cnt_q <= PreW'(PRESCALE - 1);
                        unit_cnt_q     <= unit_cnt_q - 8'd1;
                        if (unit_cnt_q == 8'd1) begin
                            state_q     <= StDrop;
                            drop_q      <= 1'b1;
                            pulse_cnt_q <= '0;
                            done_q      <= DropDoneOnEntry;
                        end
                    end else begin
                        prescale_cnt_q <= prescale_cnt_q - PreW'(1);
                    end
                end

                StDrop: begin
                    if (pulse_cnt_q == HoldW'(DROP_PULSE - 1)) begin
                        state_q <= StIdle;
                        drop_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q + HoldW'(1);
                        done_q      <= ((pulse_cnt_q + HoldW'(1)) == HoldW'(DROP_PULSE - 1));
                    end
                end

                StError: begin
                    if (pulse_cnt_q == HoldW'(ERR_HOLD - 1)) begin
                        state_q <= StIdle;
                        error_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q + HoldW'(1);
                        done_q      <= ((pulse_cnt_q + HoldW'(1)) == HoldW'(ERR_HOLD - 1));
                    end
                end

                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    drop_q  <= 1'b0;
                    error_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.drop_activated = drop_q;
    assign bus.done           = done_q;
    assign bus.error          = error_q;
    assign bus.status         = state_q;

endmodule

// File: tb/tb_drop_controller.sv
// tb_drop_controller: directed bench for drop_controller with the default parameter set.
// Each cycle the output bundle {busy, drop_activated, done, error, status} is compared
// against a hand-derived timeline for the operation in flight.
module tb_drop_controller;

    localparam int STABLE_CYCLES = 4;
    localparam int MAX_RETRY     = 3;
    localparam int H_MAX         = 200;
    localparam int PRESCALE      = 2;
    localparam int DROP_PULSE    = 3;
    localparam int ERR_HOLD      = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    drop_controller_if bus ();

    drop_controller #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRY     (MAX_RETRY),
        .H_MAX         (H_MAX),
        .PRESCALE      (PRESCALE),
        .DROP_PULSE    (DROP_PULSE),
        .ERR_HOLD      (ERR_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int observed();
        return int'({bus.busy, bus.drop_activated, bus.done, bus.error, bus.status});
    endfunction

    function automatic int expected(input int st, input bit dn);
        logic [2:0] s;
        s = 3'(st);
        return int'({(st != 0), (st == 4), dn, (st == 5), s});
    endfunction

    // One request at height h. abort_at / rst_at pulse abort / rst during that cycle
    // (0 = never); req_busy keeps drop_req high whenever the controller is busy.
    task automatic run_op(input string tag, input int h, input int abort_at, input int rst_at,
                          input bit req_busy);
        bit invalid;
        int end_nom;
        int cut_at;
        bit cut_done;
        int last;
        int st;
        bit dn;
        invalid  = (h == 0) || (h > H_MAX);
        end_nom  = invalid ? (STABLE_CYCLES + 2 + ERR_HOLD)
                           : (STABLE_CYCLES + 2 + PRESCALE * h + DROP_PULSE);
        cut_at   = 0;
        cut_done = 1'b0;
        if (abort_at > 0 && abort_at <= (invalid ? STABLE_CYCLES + 1
                                                 : STABLE_CYCLES + 1 + PRESCALE * h)) begin
            cut_at   = abort_at + 1;
            cut_done = 1'b1;
        end
        if (rst_at > 0) begin
            cut_at   = rst_at + 1;
            cut_done = 1'b0;
        end
        last = (cut_at > 0) ? cut_at + 1 : end_nom;

        bus.height   = 8'(h);
        bus.drop_req = 1'b1;
        tick();
        bus.drop_req = 1'b0;
        for (int c = 1; c <= last; c++) begin
            dn = 1'b0;
            if (cut_at > 0 && c >= cut_at) begin
                st = 0;
                dn = (c == cut_at) && cut_done;
            end else if (c <= STABLE_CYCLES) begin
                st = 1;
            end else if (c == STABLE_CYCLES + 1) begin
                st = 2;
            end else if (invalid) begin
                st = (c <= STABLE_CYCLES + 1 + ERR_HOLD) ? 5 : 0;
                dn = (c == STABLE_CYCLES + 1 + ERR_HOLD);
            end else if (c <= STABLE_CYCLES + 1 + PRESCALE * h) begin
                st = 3;
            end else if (c <= STABLE_CYCLES + 1 + PRESCALE * h + DROP_PULSE) begin
                st = 4;
                dn = (c == STABLE_CYCLES + 1 + PRESCALE * h + DROP_PULSE);
            end else begin
                st = 0;
            end
            check_value($sformatf("%s c%0d", tag, c), observed(), expected(st, dn));
            bus.abort    = (c == abort_at);
            rst          = (c == rst_at);
            bus.drop_req = req_busy && (st != 0);
            tick();
        end
        bus.abort    = 1'b0;
        bus.drop_req = 1'b0;
        rst          = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.drop_req = 1'b1;
        bus.abort    = 1'b0;
        bus.height   = 8'd5;
        tick();
        tick();
        check_value("reset held", observed(), 0);
        bus.drop_req = 1'b0;
        rst          = 1'b0;
        tick();
        check_value("reset released", observed(), 0);

        // SETTLE 1-4, EVAL 5, COUNT 6-15, DROP 16-18 with done at 18, idle at 19;
        // drop_req held through the whole operation must not disturb it.
        run_op("nominal h5", 5, 0, 0, 1'b1);
        run_op("shortest h1", 1, 0, 0, 1'b0);

        // Height 0: EVAL routes to ERROR 6-13, done at 13.
        run_op("height0", 0, 0, 0, 1'b0);

        // Height toggling every settle cycle: the fourth change errors out at cycle 5.
        bus.height   = 8'd10;
        bus.drop_req = 1'b1;
        tick();
        bus.drop_req = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            int st;
            st = (c <= 4) ? 1 : (c <= 12) ? 5 : 0;
            check_value($sformatf("unstable c%0d", c), observed(), expected(st, c == 12));
            if (c <= 4) bus.height = (c % 2 == 1) ? 8'd11 : 8'd10;
            tick();
        end
        run_op("stable h10", 10, 0, 0, 1'b0);

        run_op("over h201", 201, 0, 0, 1'b0);
        run_op("over h255", 255, 0, 0, 1'b0);
        run_op("max h200", 200, 0, 0, 1'b0);

        // Aborts: third COUNT cycle, during DROP (ignored), during SETTLE, and during EVAL
        // where it must win over the error decision for height 0.
        run_op("abort count", 50, 8, 0, 1'b0);
        run_op("abort drop", 1, 9, 0, 1'b0);
        run_op("abort settle", 7, 2, 0, 1'b0);
        run_op("abort eval", 0, 5, 0, 1'b0);

        // Reset in the second DROP cycle clears everything on the next edge.
        run_op("rst drop", 5, 0, 17, 1'b1);
        run_op("after rst", 3, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/drop_controller.md
Name: drop_controller

Overview:
- Sequences one baggage-drop operation around the combinational height datapath that fuses the four sensors.
- On a drop request it waits until the fused height is stable and validates it. It then counts down a height-proportional delay and pulses the drop actuator.
- Sits between the sensor-fusion datapath (supplies `height`) and the display/actuator logic (consumes `status` and `drop_activated`).

Parameters:
- STABLE_CYCLES, 4: consecutive cycles `height` must equal the captured value before evaluation (≥1).
- MAX_RETRY, 3: height changes tolerated during settling before the operation errors out.
- H_MAX, 200: largest height accepted; a larger height is an error.
- PRESCALE, 2: clock cycles of countdown per height unit (≥1).
- DROP_PULSE, 3: cycles `drop_activated` stays high (≥1).
- ERR_HOLD, 8: cycles spent in ERROR before returning to IDLE (≥1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- drop_req  input  1  level/pulse; sampled only in IDLE.
- abort  input  1  cancels an operation in SETTLE/EVAL/COUNT.
- height  input  8  fused height from sensor datapath; 0 = no valid sensor pair.
- busy  output  1  high in every state except IDLE.
- drop_activated  output  1  actuator strobe.
- done  output  1  one-cycle pulse on completion, error exit or abort.
- error  output  1  high while in ERROR.
- status  output  3  state code: 0 IDLE, 1 SETTLE, 2 EVAL, 3 COUNT, 4 DROP, 5 ERROR.

Behaviour:
- All outputs are registered. Reset: state IDLE; busy, drop_activated, done and error = 0; status = 0; internal h_ref, stable/retry/prescale/unit/pulse counters = 0. Reset overrides everything, including mid-DROP (drop_activated drops to 0 on the next edge).
- IDLE:
  - If drop_req = 1, capture h_ref ← height, clear counters and go to SETTLE.
  - drop_req in any other state is ignored (no queuing).
- SETTLE, each cycle:
  - If height == h_ref, stable_cnt++. When stable_cnt reaches STABLE_CYCLES, go to EVAL.
  - Otherwise h_ref ← height, stable_cnt ← 0, retry_cnt++.
  - If retry_cnt would exceed MAX_RETRY, go to ERROR.
- EVAL (exactly 1 cycle):
  - h_ref == 0 or h_ref > H_MAX → ERROR.
  - Otherwise load unit_cnt ← h_ref, prescale_cnt ← PRESCALE-1, go to COUNT.
- COUNT:
  - prescale_cnt decrements each cycle. At 0 it reloads PRESCALE-1 and unit_cnt decrements.
  - When unit_cnt reaches 0, go to DROP. COUNT lasts exactly h_ref*PRESCALE cycles.
  - Counter widths: 8-bit unit_cnt; prescale counter sized by $clog2(PRESCALE).
- DROP:
  - drop_activated = 1 for exactly DROP_PULSE cycles.
  - done = 1 in the last DROP cycle, then go to IDLE.
  - abort is ignored in DROP.
- ERROR:
  - error = 1 for ERR_HOLD cycles. done pulses in the last ERROR cycle, then go to IDLE.
- abort in SETTLE/EVAL/COUNT: next state IDLE, done = 1 for one cycle, drop_activated never asserted.
- Precedence:
  - abort beats the EVAL and SETTLE decisions in the same cycle.
  - rst beats all.
  - A COUNT expiry coinciding with abort → abort wins.
- busy is high from the cycle after drop_req is accepted until the cycle after done. status tracks state with the same registered timing.
- No arithmetic overflow: h_ref ≤ 255, and the product h_ref*PRESCALE is never formed (nested counters).

Test Plan:
- Nominal drop (STABLE_CYCLES=4, PRESCALE=2, DROP_PULSE=3), height=5 constant, drop_req at cycle 0 → SETTLE cycles 1–4, EVAL 5, COUNT 6–15, drop_activated high 16–18, done at 18, busy low at 19.
- Invalid height: height=0, drop_req → EVAL routes to ERROR; error high 8 cycles; done on the last ERROR cycle; drop_activated never high.
- Unstable height: height toggles 10/11 every cycle during SETTLE → after 4 changes (MAX_RETRY=3 exceeded) ERROR; later a stable height=10 request completes normally.
- Over-range: height=201 → ERROR; height=200 → drop after 400 COUNT cycles.
- Abort: height=50, abort asserted 3 cycles into COUNT → IDLE next cycle, done pulse, no drop_activated; abort during DROP → pulse still lasts 3 cycles.
- Reset mid-operation: rst asserted in the second DROP cycle → all outputs 0 next edge; drop_req during busy is ignored and leaves timing unchanged.
